// File: rtl/lcd_bus_snoop.sv
// Passive HD44780-style bus snooper: synchronizes the LCD bus, decodes instruction and
// data writes, and keeps a 2x16 shadow of the visible display as packed text words.
module lcd_bus_snoop #(
    parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lcd_rs,
    input  logic        lcd_rw,
    input  logic        lcd_en,
    input  logic [7:0]  lcd_data,
    output logic [31:0] text_a,
    output logic [31:0] text_b,
    output logic [31:0] text_c,
    output logic [31:0] text_d,
    output logic [31:0] text_e,
    output logic [31:0] text_f,
    output logic [31:0] text_g,
    output logic [31:0] text_h,
    output logic [6:0]  cursor_addr,
    output logic        busy,
    output logic        wr_pulse,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic        drop_err
);

    typedef enum logic {S_IDLE, S_CLR} state_t;

    state_t      r_state, w_state_next;
    logic        r_en_s1, r_en_sync, r_en_d;
    logic        r_rs_s1, r_rs_sync, r_rs_d;
    logic        r_rw_s1, r_rw_sync, r_rw_d;
    logic [7:0]  r_data_s1, r_data_sync, r_data_d;
    logic [6:0]  r_ac;
    logic        r_id, r_cg;
    logic [4:0]  r_clr_idx;
    logic        r_wr_pulse, r_cmd_valid, r_drop_err;
    logic [7:0]  r_cmd_code;

    logic        w_strobe, w_busy, w_accept, w_cmd, w_dat, w_store;
    logic [4:0]  w_store_idx;
    logic [6:0]  w_ac_inc, w_ac_dec;
    logic [255:0] w_flat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en_s1   <= 1'b0; r_en_sync   <= 1'b0; r_en_d   <= 1'b0;
            r_rs_s1   <= 1'b0; r_rs_sync   <= 1'b0; r_rs_d   <= 1'b0;
            r_rw_s1   <= 1'b0; r_rw_sync   <= 1'b0; r_rw_d   <= 1'b0;
            r_data_s1 <= 8'h00; r_data_sync <= 8'h00; r_data_d <= 8'h00;
        end else begin
            r_en_s1   <= lcd_en;   r_en_sync   <= r_en_s1;   r_en_d   <= r_en_sync;
            r_rs_s1   <= lcd_rs;   r_rs_sync   <= r_rs_s1;   r_rs_d   <= r_rs_sync;
            r_rw_s1   <= lcd_rw;   r_rw_sync   <= r_rw_s1;   r_rw_d   <= r_rw_sync;
            r_data_s1 <= lcd_data; r_data_sync <= r_data_s1; r_data_d <= r_data_sync;
        end
    end

    // Falling edge of the synchronized strobe; the delayed stage carries the transfer fields.
    assign w_strobe    = r_en_d & ~r_en_sync;
    assign w_busy      = (r_state == S_CLR);
    assign w_accept    = w_strobe & ~w_busy & ~r_rw_d;
    assign w_cmd       = w_accept & ~r_rs_d;
    assign w_dat       = w_accept & r_rs_d & ~r_cg;
    assign w_store     = w_dat & (r_ac[5:4] == 2'b00);
    assign w_store_idx = {r_ac[6], r_ac[3:0]};

    assign w_ac_inc = (r_ac == 7'h27) ? 7'h40 :
                      (r_ac == 7'h67) ? 7'h00 : r_ac + 7'd1;
    assign w_ac_dec = (r_ac == 7'h00) ? 7'h67 :
                      (r_ac == 7'h40) ? 7'h27 : r_ac - 7'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_cmd && r_data_d == 8'h01) w_state_next = S_CLR;
            S_CLR:  if (r_clr_idx == 5'd31) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ac        <= 7'h00;
            r_id        <= 1'b1;
            r_cg        <= 1'b0;
            r_clr_idx   <= 5'd0;
            r_wr_pulse  <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_code  <= 8'h00;
            r_drop_err  <= 1'b0;
        end else begin
            r_wr_pulse  <= w_dat;
            r_cmd_valid <= w_cmd;
            r_clr_idx   <= (r_state == S_CLR) ? r_clr_idx + 5'd1 : 5'd0;
            if (w_strobe && w_busy)
                r_drop_err <= 1'b1;
            if (w_cmd) begin
                r_cmd_code <= r_data_d;
                // Leading-one decode; 0x08-0x3F and 0x00 leave state alone.
                if (r_data_d[7]) begin
                    r_ac <= r_data_d[6:0];
                    r_cg <= 1'b0;
                end else if (r_data_d[6]) begin
                    r_cg <= 1'b1;
                end else if (r_data_d[5:3] == 3'b000) begin
                    if (r_data_d[2]) begin
                        r_id <= r_data_d[1];
                    end else if (r_data_d[1]) begin
                        r_ac <= 7'h00;
                        r_cg <= 1'b0;
                    end else if (r_data_d[0]) begin
                        r_ac <= 7'h00;
                        r_id <= 1'b1;
                        r_cg <= 1'b0;
                    end
                end
            end else if (w_dat) begin
                r_ac <= r_id ? w_ac_inc : w_ac_dec;
            end
        end
    end

    // Shadow cell gi holds line gi[4], column gi[3:0]; lowest column sits in the top byte.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_cell
            logic [7:0] r_cell;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    r_cell <= CLEAR_CHAR;
                else if (r_state == S_CLR && r_clr_idx == 5'(gi))
                    r_cell <= CLEAR_CHAR;
                else if (w_store && w_store_idx == 5'(gi))
                    r_cell <= r_data_d;
            end
            assign w_flat[255 - 8*gi -: 8] = r_cell;
        end
    endgenerate

    assign text_a      = w_flat[255:224];
    assign text_b      = w_flat[223:192];
    assign text_c      = w_flat[191:160];
    assign text_d      = w_flat[159:128];
    assign text_e      = w_flat[127:96];
    assign text_f      = w_flat[95:64];
    assign text_g      = w_flat[63:32];
    assign text_h      = w_flat[31:0];
    assign cursor_addr = r_ac;
    assign busy        = w_busy;
    assign wr_pulse    = r_wr_pulse;
    assign cmd_valid   = r_cmd_valid;
    assign cmd_code    = r_cmd_code;
    assign drop_err    = r_drop_err;

endmodule

// File: tb/tb_lcd_bus_snoop.sv
// Directed bench for lcd_bus_snoop: drives bus transfers and checks the shadow and status.
module tb_lcd_bus_snoop;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0;
    logic [7:0]  lcd_data = 8'h00;
    logic [31:0] text_a, text_b, text_c, text_d, text_e, text_f, text_g, text_h;
    logic [6:0]  cursor_addr;
    logic        busy, wr_pulse, cmd_valid, drop_err;
    logic [7:0]  cmd_code;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0, cmd_cnt = 0, busy_cnt = 0;
    int wr_snap, cmd_snap, busy_snap;

    always #5 clk = ~clk;

    lcd_bus_snoop #(.CLEAR_CHAR(8'h20)) dut (
        .clk(clk), .reset(reset),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data),
        .text_a(text_a), .text_b(text_b), .text_c(text_c), .text_d(text_d),
        .text_e(text_e), .text_f(text_f), .text_g(text_g), .text_h(text_h),
        .cursor_addr(cursor_addr), .busy(busy), .wr_pulse(wr_pulse),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .drop_err(drop_err)
    );

    always @(posedge clk) begin
        if (wr_pulse)  wr_cnt   <= wr_cnt + 1;
        if (cmd_valid) cmd_cnt  <= cmd_cnt + 1;
        if (busy)      busy_cnt <= busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic logic [31:0] get_text(input int i);
        case (i)
            0: return text_a; 1: return text_b; 2: return text_c; 3: return text_d;
            4: return text_e; 5: return text_f; 6: return text_g; default: return text_h;
        endcase
    endfunction

    task automatic check_all_text(input string tag, input logic [31:0] exp);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_text%0d", tag, i), 64'(get_text(i)), 64'(exp));
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_op(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
        wait_clk(4);
        lcd_en = 1'b0;
        wait_clk(5);
    endtask

    task automatic check_reset_state(input string tag);
        check_all_text(tag, 32'h20202020);
        check({tag, "_cursor"}, 64'(cursor_addr), 64'h00);
        check({tag, "_busy"},   64'(busy),        64'h0);
        check({tag, "_drop"},   64'(drop_err),    64'h0);
        check({tag, "_wr"},     64'(wr_pulse),    64'h0);
        check({tag, "_cmdv"},   64'(cmd_valid),   64'h0);
        check({tag, "_code"},   64'(cmd_code),    64'h00);
    endtask

    initial begin
        wait_clk(3);
        reset = 1'b0;
        wait_clk(2);
        check_reset_state("rst");

        // Line 1 write "HI"
        wr_snap = wr_cnt; cmd_snap = cmd_cnt;
        bus_op(1'b0, 1'b0, 8'h80);
        bus_op(1'b1, 1'b0, 8'h48);
        bus_op(1'b1, 1'b0, 8'h49);
        check("hi_text_a", 64'(text_a), 64'h48492020);
        check("hi_cursor", 64'(cursor_addr), 64'h02);
        check("hi_wr_cnt", 64'(wr_cnt - wr_snap), 64'd2);
        check("hi_cmd_cnt", 64'(cmd_cnt - cmd_snap), 64'd1);
        check("hi_code", 64'(cmd_code), 64'h80);

        // Last column of line 2, then an off-screen address
        bus_op(1'b0, 1'b0, 8'hCF);
        bus_op(1'b1, 1'b0, 8'h41);
        bus_op(1'b1, 1'b0, 8'h42);
        check("l2end_text_h", 64'(text_h), 64'h20202041);
        check("l2end_text_g", 64'(text_g), 64'h20202020);
        check("l2end_cursor", 64'(cursor_addr), 64'h51);

        // Increment wrap 0x27 -> 0x40 with no store
        bus_op(1'b0, 1'b0, 8'hA7);
        bus_op(1'b1, 1'b0, 8'h5A);
        check("incwrap_cursor", 64'(cursor_addr), 64'h40);
        check("incwrap_text_a", 64'(text_a), 64'h48492020);
        check("incwrap_text_e", 64'(text_e), 64'h20202020);
        check("incwrap_text_h", 64'(text_h), 64'h20202041);

        // Decrement wrap 0x40 -> 0x27, storing at line 2 column 0
        bus_op(1'b0, 1'b0, 8'h04);
        bus_op(1'b0, 1'b0, 8'hC0);
        bus_op(1'b1, 1'b0, 8'h33);
        check("decwrap_cursor", 64'(cursor_addr), 64'h27);
        check("decwrap_text_e", 64'(text_e), 64'h33202020);
        bus_op(1'b0, 1'b0, 8'h06);

        // Fill line 1, then clear with a strobe landing mid-sweep
        bus_op(1'b0, 1'b0, 8'h80);
        for (int i = 0; i < 16; i++) bus_op(1'b1, 1'b0, 8'h31);
        check("fill_text_a", 64'(text_a), 64'h31313131);
        check("fill_text_d", 64'(text_d), 64'h31313131);
        check("fill_cursor", 64'(cursor_addr), 64'h10);
        busy_snap = busy_cnt; wr_snap = wr_cnt;
        bus_op(1'b0, 1'b0, 8'h01);
        bus_op(1'b1, 1'b0, 8'h58);
        wait_clk(40);
        check("clr_busy_cycles", 64'(busy_cnt - busy_snap), 64'd32);
        check("clr_busy", 64'(busy), 64'h0);
        check_all_text("clr", 32'h20202020);
        check("clr_drop", 64'(drop_err), 64'h1);
        check("clr_cursor", 64'(cursor_addr), 64'h00);
        check("clr_wr_cnt", 64'(wr_cnt - wr_snap), 64'd0);
        check("clr_code", 64'(cmd_code), 64'h01);

        // CGRAM-targeted data is ignored; reads are ignored
        wr_snap = wr_cnt;
        bus_op(1'b0, 1'b0, 8'h40);
        bus_op(1'b1, 1'b0, 8'h1F);
        check("cg_wr_cnt", 64'(wr_cnt - wr_snap), 64'd0);
        check("cg_cursor", 64'(cursor_addr), 64'h00);
        check("cg_text_a", 64'(text_a), 64'h20202020);
        bus_op(1'b0, 1'b0, 8'h80);
        bus_op(1'b1, 1'b0, 8'h37);
        check("dd_text_a", 64'(text_a), 64'h37202020);
        check("dd_cursor", 64'(cursor_addr), 64'h01);
        check("dd_wr_cnt", 64'(wr_cnt - wr_snap), 64'd1);
        check("drop_sticky", 64'(drop_err), 64'h1);
        wr_snap = wr_cnt; cmd_snap = cmd_cnt;
        bus_op(1'b1, 1'b1, 8'h55);
        bus_op(1'b0, 1'b1, 8'h01);
        check("rd_cursor", 64'(cursor_addr), 64'h01);
        check("rd_text_a", 64'(text_a), 64'h37202020);
        check("rd_counts", 64'((wr_cnt - wr_snap) + (cmd_cnt - cmd_snap)), 64'd0);

        // Asynchronous reset mid-sweep
        bus_op(1'b0, 1'b0, 8'hCF);
        bus_op(1'b1, 1'b0, 8'h39);
        check("pre_text_h", 64'(text_h), 64'h20202039);
        bus_op(1'b0, 1'b0, 8'h01);
        wait_clk(3);
        check("midclr_busy", 64'(busy), 64'h1);
        #2 reset = 1'b1;
        #1 check_reset_state("async");
        wait_clk(2);
        reset = 1'b0;
        wait_clk(2);
        check_reset_state("rel");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
